// File: rtl/servo_pulse_decoder.sv
// Servo PWM decoder: measures high width and rising-to-rising period of a synchronized input,
// publishing angle/width/period for in-range frames and flagging bad frames or signal loss.
module servo_pulse_decoder #(
    parameter int MIN_HIGH   = 50000,
    parameter int MAX_HIGH   = 100000,
    parameter int STEP       = 500,
    parameter int PERIOD_MIN = 900000,
    parameter int PERIOD_MAX = 1100000,
    parameter int TIMEOUT    = 1200000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        servo_in,
    output logic [9:0]  angle,
    output logic [20:0] pulse_width,
    output logic [20:0] period,
    output logic        valid,
    output logic        frame_err,
    output logic        lost
);
    localparam logic [20:0] CNT_MAX   = 21'h1F_FFFF;
    localparam logic [20:0] MIN_W     = 21'(MIN_HIGH);
    localparam logic [20:0] MAX_W     = 21'(MAX_HIGH);
    localparam logic [20:0] PMIN_W    = 21'(PERIOD_MIN);
    localparam logic [20:0] PMAX_W    = 21'(PERIOD_MAX);
    localparam logic [20:0] TIMEOUT_W = 21'(TIMEOUT);
    localparam logic [20:0] STEP_LAST = 21'(STEP - 1);

    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;
    state_t state, state_nxt;

    logic        sync1, sync2, sync3;
    logic        rise, fall;
    logic [20:0] width_cnt, period_cnt, step_cnt;
    logic [20:0] width_inc, period_inc;
    logic [9:0]  angle_acc;
    logic        seen_edge, timeout, frame_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= servo_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise       = sync2 & ~sync3;
    assign fall       = ~sync2 & sync3;
    assign width_inc  = (width_cnt == CNT_MAX) ? width_cnt : width_cnt + 21'd1;
    assign period_inc = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + 21'd1;
    // WAIT_RISE only watches for loss once an edge has been seen since enable
    assign timeout    = (period_cnt == TIMEOUT_W) && ((state != WAIT_RISE) || seen_edge);
    assign frame_ok   = (width_cnt >= MIN_W) && (width_cnt <= MAX_W) &&
                        (period_cnt >= PMIN_W) && (period_cnt <= PMAX_W);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_RISE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable || timeout) begin
            state_nxt = WAIT_RISE;
        end else begin
            case (state)
                WAIT_RISE: if (rise) state_nxt = HIGH;
                HIGH:      if (fall) state_nxt = LOW;
                LOW:       if (rise) state_nxt = HIGH;
                default:   state_nxt = WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            width_cnt   <= '0;
            period_cnt  <= '0;
            step_cnt    <= '0;
            angle_acc   <= '0;
            seen_edge   <= 1'b0;
            angle       <= '0;
            pulse_width <= '0;
            period      <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            lost        <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!enable || timeout) begin
                width_cnt  <= '0;
                period_cnt <= '0;
                step_cnt   <= '0;
                angle_acc  <= '0;
                if (!enable) begin
                    seen_edge <= 1'b0;
                end else begin
                    lost <= 1'b1;
                end
            end else begin
                if (rise) begin
                    seen_edge <= 1'b1;
                end
                if (rise && state == LOW) begin
                    if (frame_ok) begin
                        angle       <= angle_acc;
                        pulse_width <= width_cnt;
                        period      <= period_cnt;
                        valid       <= 1'b1;
                        lost        <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                if (rise && state != HIGH) begin
                    width_cnt  <= 21'd1;
                    period_cnt <= 21'd1;
                    step_cnt   <= '0;
                    angle_acc  <= '0;
                end else if (state == HIGH) begin
                    period_cnt <= period_inc;
                    // angle = floor((width - MIN_HIGH) / STEP), tallied one sample at a time
                    if (!fall && width_cnt != CNT_MAX) begin
                        width_cnt <= width_inc;
                        if (width_inc > MIN_W) begin
                            if (step_cnt == STEP_LAST) begin
                                step_cnt <= '0;
                                if (angle_acc != 10'h3FF) begin
                                    angle_acc <= angle_acc + 10'd1;
                                end
                            end else begin
                                step_cnt <= step_cnt + 21'd1;
                            end
                        end
                    end
                end else if (state == LOW || seen_edge) begin
                    period_cnt <= period_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder: frame-level reference model feeds a scoreboard checked by a strobe monitor.
module tb_servo_pulse_decoder;
    localparam int MIN_HIGH   = 100;
    localparam int MAX_HIGH   = 300;
    localparam int STEP       = 2;
    localparam int PERIOD_MIN = 900;
    localparam int PERIOD_MAX = 1100;
    localparam int TIMEOUT    = 1200;

    logic        clock = 1'b0;
    logic        reset, enable, servo_in;
    logic [9:0]  angle;
    logic [20:0] pulse_width, period;
    logic        valid, frame_err, lost;

    servo_pulse_decoder #(
        .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH), .STEP(STEP),
        .PERIOD_MIN(PERIOD_MIN), .PERIOD_MAX(PERIOD_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .servo_in(servo_in),
        .angle(angle), .pulse_width(pulse_width), .period(period),
        .valid(valid), .frame_err(frame_err), .lost(lost)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit ok;
        int ang;
        int w;
        int p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    logic lost_q = 1'b0;

    // Reference model state, kept in input-cycle terms
    bit m_open = 0, m_en = 1, m_rst = 1, m_lost = 0, lvl = 0;
    int m_since = 0, m_width = 0, m_ang = 0, m_pw = 0, m_per = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_rise();
        exp_t e;
        if (m_rst || !m_en) return;
        if (m_open) begin
            e.w   = m_width;
            e.p   = m_since;
            e.ok  = (m_width >= MIN_HIGH) && (m_width <= MAX_HIGH) &&
                    (m_since >= PERIOD_MIN) && (m_since <= PERIOD_MAX);
            e.ang = e.ok ? (m_width - MIN_HIGH) / STEP : 0;
            if (e.ok) begin
                m_ang  = e.ang;
                m_pw   = e.w;
                m_per  = e.p;
                m_lost = 0;
            end
            sb.push_back(e);
        end
        m_open  = 1;
        m_since = 0;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (m_open && m_since >= TIMEOUT) begin
                m_open = 0;
                m_lost = 1;
            end
            if (v && !lvl) model_rise();
            else if (!v && lvl) m_width = m_since;
            servo_in = v;
            lvl      = v;
            m_since++;
        end
    endtask

    task automatic send_frame(input int h, input int p);
        drive(1'b1, h);
        drive(1'b0, p - h);
    endtask

    task automatic set_enable(input logic e);
        enable = e;
        m_en   = e;
        if (!e) m_open = 0;
    endtask

    task automatic set_reset(input logic r);
        reset = r;
        m_rst = r;
        if (r) begin
            m_open = 0;
            m_lost = 0;
            m_ang  = 0;
            m_pw   = 0;
            m_per  = 0;
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_angle"}, int'(angle), m_ang);
        check({tag, "_pulse_width"}, int'(pulse_width), m_pw);
        check({tag, "_period"}, int'(period), m_per);
        check({tag, "_lost"}, int'(lost), int'(m_lost));
    endtask

    always @(negedge clock) begin
        cyc++;
        if (valid || frame_err) begin
            check("strobe_exclusive", int'(valid && frame_err), 0);
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b, no frame expected (cycle %0d)",
                         valid, frame_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_is_valid", int'(valid), int'(mon_e.ok));
                if (mon_e.ok && valid) begin
                    check("frame_angle", int'(angle), mon_e.ang);
                    check("frame_pulse_width", int'(pulse_width), mon_e.w);
                    check("frame_period", int'(period), mon_e.p);
                    check("frame_lost_clear", int'(lost), 0);
                end
            end
            last_strobe = cyc;
        end
        if (lost && !lost_q) check("lost_delay", cyc - last_strobe, TIMEOUT);
        lost_q = lost;
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        servo_in = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_valid", int'(valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check_hold("reset");
        set_reset(1'b0);
        drive(1'b0, 20);

        // Nominal frames: first only opens, following ones decode to angle 50
        repeat (3) send_frame(200, 1000);
        check_hold("nominal");
        send_frame(100, 1000);
        send_frame(300, 1000);
        check_hold("angle0");
        send_frame(140, 1000);
        check_hold("angle100");
        send_frame(99, 1000);
        check_hold("angle20");
        send_frame(200, 1000);
        check_hold("short_width_holds");

        // Glitch and range boundaries
        send_frame(1, 1000);
        send_frame(200, 899);
        send_frame(200, 900);
        send_frame(300, 1100);
        send_frame(301, 1101);
        send_frame(200, 1000);
        check_hold("boundaries");

        for (int i = 0; i < 20; i++) begin
            send_frame(int'($urandom_range(310, 90)), int'($urandom_range(1120, 880)));
            check_hold("random");
        end

        // Signal loss and recovery
        send_frame(200, 1000);
        drive(1'b0, 400);
        check_hold("lost_set");
        send_frame(200, 1000);
        check_hold("lost_still_set");
        send_frame(160, 1000);
        send_frame(220, 1000);
        check_hold("lost_cleared");

        // Reset in the middle of a high phase
        drive(1'b1, 50);
        set_reset(1'b1);
        drive(1'b1, 150);
        drive(1'b0, 100);
        check_hold("in_reset");
        set_reset(1'b0);
        drive(1'b0, 500);
        check_hold("after_reset");
        send_frame(200, 1000);
        check_hold("reset_first_rise");
        send_frame(240, 1000);
        check_hold("reset_second_rise");

        // Enable dropped mid-frame
        drive(1'b1, 50);
        set_enable(1'b0);
        drive(1'b1, 150);
        drive(1'b0, 300);
        check_hold("enable_low");
        set_enable(1'b1);
        drive(1'b0, 300);
        send_frame(200, 1000);
        send_frame(260, 1000);
        drive(1'b1, 5);
        drive(1'b0, 20);
        check_hold("final");
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
